regfile_wb_arbiter: RTL and testbench
=====================================

Name: regfile_wb_arbiter

Overview:
- Shares the single register-file write port (RD / RD_DATA / WRITE_ENABLE) between the single-cycle ALU writeback path and the multi-cycle MUL/DIV unit of the RV64IM core.
- Buffers completed MUL/DIV results in a small FIFO and keeps a 32-entry busy scoreboard of registers with MUL/DIV results still pending.
- Drives a hazard flag that the decode stage uses to stall.
- Sits between the execute/writeback stage and the register file.

Parameters:
- XLEN, 64, data width of register values.
- FIFO_DEPTH, 2, MUL/DIV result buffer entries (power of two, ≥2).
- STARVE_LIMIT, 4, consecutive ALU grants allowed while the FIFO is non-empty before a forced drain.

Ports:
- CLK  input  1  core clock, rising edge
- RESET  input  1  asynchronous, active-high reset
- ALU_VALID  input  1  ALU result present this cycle
- ALU_RD  input  5  ALU destination register
- ALU_DATA  input  XLEN  ALU result
- ALU_READY  output  1  ALU result accepted; upstream holds its result while low
- MD_VALID  input  1  MUL/DIV result present
- MD_RD  input  5  MUL/DIV destination register
- MD_DATA  input  XLEN  MUL/DIV result
- MD_READY  output  1  FIFO not full
- ISSUE_VALID  input  1  MUL/DIV op dispatched this cycle
- ISSUE_RD  input  5  destination of the dispatched op
- CHK_R1, CHK_R2, CHK_RD  input  5 each  decode-stage source/destination registers to check
- HAZARD  output  1  any checked register is busy
- RD  output  5  to register file
- RD_DATA  output  XLEN  to register file
- WRITE_ENABLE  output  1  to register file

Behaviour:
- Reset (async, any time): FIFO empty, pointers 0, scoreboard all 0, starve counter 0, state NORMAL, WRITE_ENABLE=0, RD=0, RD_DATA=0. MD_READY=1 after reset. ALU_READY=1 after reset.
- Write-port outputs are registered.
  - A grant in cycle N drives RD/RD_DATA/WRITE_ENABLE during cycle N+1.
  - With no grant, WRITE_ENABLE=0 and RD/RD_DATA hold their previous values.
- FIFO:
  - Pushes on MD_VALID && MD_READY.
  - Pops on an MD grant.
  - MD_READY = !full, combinational from the count.
  - When full, a push and a pop in the same cycle is not allowed, because MD_READY=0.
  - When not full, a push and a pop in the same cycle is allowed; the count is unchanged.
  - Pointers wrap modulo FIFO_DEPTH.
  - A push into an empty FIFO is not grantable until the next cycle (no bypass).
- Arbitration is a two-state FSM.
  - NORMAL state:
    - ALU_READY=1.
    - If ALU_VALID, grant ALU; otherwise, if the FIFO is non-empty, grant the FIFO head.
    - The starve counter increments on an ALU grant while the FIFO is non-empty. It clears on an MD grant or when the FIFO is empty.
    - When the counter reaches STARVE_LIMIT, go to DRAIN.
  - DRAIN state:
    - ALU_READY=0.
    - Grant the FIFO head, clear the counter, and return to NORMAL next cycle.
    - DRAIN always lasts exactly one cycle.
- Writes with RD=0: the grant still occurs and the FIFO still pops, but WRITE_ENABLE is driven 0 (x0 is never written).
- Scoreboard, busy[31:0]:
  - Set busy[ISSUE_RD] on ISSUE_VALID.
  - Clear busy[rd] when an MD entry with that rd is granted.
  - If a set and a clear hit the same register in the same cycle, the set wins.
  - busy[0] is never set.
- HAZARD = busy[CHK_R1] | busy[CHK_R2] | busy[CHK_RD]. It is combinational from the registered scoreboard.
  - HAZARD does not see the same-cycle ISSUE_VALID.
  - The decode stage must not issue to a register with busy set, so WAW ordering between the ALU and MUL/DIV results is guaranteed by HAZARD.
- ALU results are never dropped: the ALU result is consumed only on ALU_VALID && ALU_READY.

Decomposition:
- Shared package entries:
  - XLEN.
  - Register-index width (5).
  - Arbiter state enum {NORMAL, DRAIN}.
  - The FIFO entry struct {rd[4:0], data[XLEN-1:0]}.
- One sub-module is natural: wb_result_fifo, a parameterized synchronous FIFO with full/empty/count outputs, same CLK/RESET.
- The arbiter FSM and the scoreboard live in the top module.

Test Plan:
- Reset, then MD_VALID=1, MD_RD=5, MD_DATA=0xAB for one cycle with the ALU idle:
  - the entry is grantable the cycle after the push;
  - WRITE_ENABLE=1, RD=5, RD_DATA=0xAB one cycle after that grant.
- ALU_VALID=1 continuously, ALU_RD=3, with one FIFO entry pending and STARVE_LIMIT=4:
  - 4 ALU writes to x3;
  - then ALU_READY=0 for exactly one cycle while the MD entry is written;
  - then ALU writes resume with the held data.
- Three MD results back to back with the ALU busy and FIFO_DEPTH=2:
  - MD_READY drops after 2 pushes;
  - the third result is held until a pop, then accepted;
  - write order matches push order.
- ISSUE_VALID with ISSUE_RD=7, then CHK_R2=7:
  - HAZARD=1 until the cycle after the MD grant for rd 7, then 0.
- In the same cycle, an MD grant clears rd 9 and ISSUE_VALID sets rd 9:
  - busy[9] remains 1.
- ALU_VALID with ALU_RD=0 and ALU_DATA=0xFF:
  - ALU_READY=1 and WRITE_ENABLE stays 0.
- RESET asserted asynchronously with 2 FIFO entries and busy bits set:
  - immediately FIFO empty, HAZARD=0, WRITE_ENABLE=0, MD_READY=1.

Source files
------------

// File: rtl/regfile_wb_arbiter_pkg.sv
// rtl/regfile_wb_arbiter_pkg.sv - shared types and widths for the writeback port arbiter
package regfile_wb_arbiter_pkg;

   localparam int XLEN     = 64;
   localparam int REG_W    = 5;
   localparam int NUM_REGS = 32;

   typedef enum logic {
      NORMAL = 1'b0,
      DRAIN  = 1'b1
   } arb_state_t;

   typedef struct packed {
      logic [REG_W-1:0] rd;
      logic [XLEN-1:0]  data;
   } md_entry_t;

endpackage

// File: rtl/wb_result_fifo.sv
// rtl/wb_result_fifo.sv - synchronous FIFO buffering completed MUL/DIV results
module wb_result_fifo
   import regfile_wb_arbiter_pkg::*;
#(
   parameter int DEPTH = 2,
   localparam int CNT_W = $clog2(DEPTH + 1)
) (
   input  logic             CLK,
   input  logic             RESET,
   input  logic             push,
   input  md_entry_t        push_entry,
   input  logic             pop,
   output md_entry_t        head,
   output logic             full,
   output logic             empty,
   output logic [CNT_W-1:0] count
);

   localparam int PTR_W = $clog2(DEPTH);

   md_entry_t        mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign full    = (count == CNT_W'(DEPTH));
   assign empty   = (count == '0);
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign head    = mem[rd_ptr];

   // DEPTH is a power of two, so pointer overflow is the modulo wrap
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         if (do_push && !do_pop)      count <= count + 1'b1;
         else if (do_pop && !do_push) count <= count - 1'b1;
      end
   end

   always_ff @(posedge CLK) begin
      if (do_push) mem[wr_ptr] <= push_entry;
   end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// rtl/regfile_wb_arbiter.sv - shares the register-file write port between ALU and MUL/DIV results
module regfile_wb_arbiter
   import regfile_wb_arbiter_pkg::*;
#(
   parameter int FIFO_DEPTH   = 2,
   parameter int STARVE_LIMIT = 4
) (
   input  logic             CLK,
   input  logic             RESET,
   input  logic             ALU_VALID,
   input  logic [REG_W-1:0] ALU_RD,
   input  logic [XLEN-1:0]  ALU_DATA,
   output logic             ALU_READY,
   input  logic             MD_VALID,
   input  logic [REG_W-1:0] MD_RD,
   input  logic [XLEN-1:0]  MD_DATA,
   output logic             MD_READY,
   input  logic             ISSUE_VALID,
   input  logic [REG_W-1:0] ISSUE_RD,
   input  logic [REG_W-1:0] CHK_R1,
   input  logic [REG_W-1:0] CHK_R2,
   input  logic [REG_W-1:0] CHK_RD,
   output logic             HAZARD,
   output logic [REG_W-1:0] RD,
   output logic [XLEN-1:0]  RD_DATA,
   output logic             WRITE_ENABLE
);

   localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
   localparam int SC_W  = $clog2(STARVE_LIMIT + 1);

   arb_state_t          state;
   arb_state_t          state_next;
   logic [SC_W-1:0]     starve;
   logic [SC_W-1:0]     starve_next;
   logic [NUM_REGS-1:0] busy;
   logic [NUM_REGS-1:0] busy_next;
   logic                alu_grant;
   logic                md_grant;
   logic                md_push;
   md_entry_t           push_entry;
   md_entry_t           fifo_head;
   logic                fifo_full;
   logic                fifo_empty;
   logic [CNT_W-1:0]    fifo_count;

   assign MD_READY   = !fifo_full;
   assign md_push    = MD_VALID && MD_READY;
   assign push_entry = '{rd: MD_RD, data: MD_DATA};

   wb_result_fifo #(
      .DEPTH (FIFO_DEPTH)
   ) fifo (
      .CLK        (CLK),
      .RESET      (RESET),
      .push       (md_push),
      .push_entry (push_entry),
      .pop        (md_grant),
      .head       (fifo_head),
      .full       (fifo_full),
      .empty      (fifo_empty),
      .count      (fifo_count)
   );

   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         state  <= NORMAL;
         starve <= '0;
         busy   <= '0;
      end else begin
         state  <= state_next;
         starve <= starve_next;
         busy   <= busy_next;
      end
   end

   always_comb begin
      state_next  = state;
      starve_next = starve;
      alu_grant   = 1'b0;
      md_grant    = 1'b0;
      ALU_READY   = 1'b1;
      case (state)
         NORMAL: begin
            if (ALU_VALID)        alu_grant = 1'b1;
            else if (!fifo_empty) md_grant  = 1'b1;
            if (fifo_count == '0 || md_grant) begin
               starve_next = '0;
            end else if (alu_grant) begin
               starve_next = starve + 1'b1;
               if (starve_next == SC_W'(STARVE_LIMIT)) state_next = DRAIN;
            end
         end
         DRAIN: begin
            // one forced cycle for the oldest MUL/DIV result; ALU is held off
            ALU_READY   = 1'b0;
            md_grant    = !fifo_empty;
            starve_next = '0;
            state_next  = NORMAL;
         end
         default: state_next = NORMAL;
      endcase
   end

   // issue set is applied after the grant clear so a same-cycle reissue stays busy
   always_comb begin
      busy_next = busy;
      if (md_grant) busy_next[fifo_head.rd] = 1'b0;
      if (ISSUE_VALID && ISSUE_RD != '0) busy_next[ISSUE_RD] = 1'b1;
   end

   assign HAZARD = busy[CHK_R1] | busy[CHK_R2] | busy[CHK_RD];

   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         RD           <= '0;
         RD_DATA      <= '0;
         WRITE_ENABLE <= 1'b0;
      end else begin
         WRITE_ENABLE <= 1'b0;
         if (alu_grant) begin
            RD           <= ALU_RD;
            RD_DATA      <= ALU_DATA;
            WRITE_ENABLE <= (ALU_RD != '0);
         end else if (md_grant) begin
            RD           <= fifo_head.rd;
            RD_DATA      <= fifo_head.data;
            WRITE_ENABLE <= (fifo_head.rd != '0);
         end
      end
   end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// tb/tb_regfile_wb_arbiter.sv - randomized and directed bench against a queue-based reference model
module tb_regfile_wb_arbiter;

   localparam int XLEN  = 64;
   localparam int DEPTH = 2;
   localparam int LIMIT = 4;

   typedef struct {
      logic [4:0]      rd;
      logic [XLEN-1:0] data;
   } ent_t;

   logic            clk = 1'b0;
   logic            rst;
   logic            alu_valid;
   logic [4:0]      alu_rd;
   logic [XLEN-1:0] alu_data;
   logic            alu_ready;
   logic            md_valid;
   logic [4:0]      md_rd;
   logic [XLEN-1:0] md_data;
   logic            md_ready;
   logic            issue_valid;
   logic [4:0]      issue_rd;
   logic [4:0]      chk_r1;
   logic [4:0]      chk_r2;
   logic [4:0]      chk_rd;
   logic            hazard;
   logic [4:0]      rd;
   logic [XLEN-1:0] rd_data;
   logic            write_enable;

   int n_checks = 0;
   int n_pass   = 0;

   ent_t            m_q[$];
   bit [31:0]       m_busy;
   int              m_starve;
   bit              m_drain;
   bit              m_we;
   logic [4:0]      m_rd;
   logic [XLEN-1:0] m_data;
   bit              m_alu_acc;
   bit              m_md_acc;
   int              order[$];

   always #5 clk = ~clk;

   regfile_wb_arbiter #(
      .FIFO_DEPTH   (DEPTH),
      .STARVE_LIMIT (LIMIT)
   ) dut (
      .CLK          (clk),
      .RESET        (rst),
      .ALU_VALID    (alu_valid),
      .ALU_RD       (alu_rd),
      .ALU_DATA     (alu_data),
      .ALU_READY    (alu_ready),
      .MD_VALID     (md_valid),
      .MD_RD        (md_rd),
      .MD_DATA      (md_data),
      .MD_READY     (md_ready),
      .ISSUE_VALID  (issue_valid),
      .ISSUE_RD     (issue_rd),
      .CHK_R1       (chk_r1),
      .CHK_R2       (chk_r2),
      .CHK_RD       (chk_rd),
      .HAZARD       (hazard),
      .RD           (rd),
      .RD_DATA      (rd_data),
      .WRITE_ENABLE (write_enable)
   );

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
   endtask

   task automatic idle_inputs();
      alu_valid   = 1'b0;
      alu_rd      = '0;
      alu_data    = '0;
      md_valid    = 1'b0;
      md_rd       = '0;
      md_data     = '0;
      issue_valid = 1'b0;
      issue_rd    = '0;
      chk_r1      = '0;
      chk_r2      = '0;
      chk_rd      = '0;
   endtask

   task automatic model_reset();
      m_q.delete();
      m_busy    = '0;
      m_starve  = 0;
      m_drain   = 1'b0;
      m_we      = 1'b0;
      m_rd      = '0;
      m_data    = '0;
      m_alu_acc = 1'b1;
      m_md_acc  = 1'b1;
   endtask

   // One clock of the reference: who gets the port, then scoreboard and queue bookkeeping.
   task automatic model_advance();
      bit   give_alu;
      bit   give_md;
      int   size_now;
      ent_t e;
      size_now  = m_q.size();
      give_alu  = 1'b0;
      give_md   = 1'b0;
      m_alu_acc = alu_valid && !m_drain;
      m_md_acc  = md_valid && (size_now < DEPTH);
      if (m_drain)        give_md  = (size_now > 0);
      else if (alu_valid) give_alu = 1'b1;
      else                give_md  = (size_now > 0);

      m_we = 1'b0;
      if (give_alu) begin
         m_rd = alu_rd; m_data = alu_data; m_we = (alu_rd != 0);
      end else if (give_md) begin
         m_rd = m_q[0].rd; m_data = m_q[0].data; m_we = (m_q[0].rd != 0);
      end

      if (m_drain) begin
         m_starve = 0;
         m_drain  = 1'b0;
      end else if (size_now == 0 || give_md) begin
         m_starve = 0;
      end else if (give_alu) begin
         m_starve = m_starve + 1;
         if (m_starve == LIMIT) m_drain = 1'b1;
      end

      if (give_md) m_busy[m_q[0].rd] = 1'b0;
      if (issue_valid && issue_rd != 0) m_busy[issue_rd] = 1'b1;

      if (give_md) void'(m_q.pop_front());
      if (m_md_acc) begin
         e.rd = md_rd; e.data = md_data;
         m_q.push_back(e);
      end
   endtask

   // Called at posedge+1 with this cycle's inputs driven; returns at the next posedge+1.
   task automatic step();
      #1;
      check_eq("alu_ready", alu_ready, !m_drain);
      check_eq("md_ready", md_ready, m_q.size() < DEPTH);
      check_eq("hazard", hazard, m_busy[chk_r1] | m_busy[chk_r2] | m_busy[chk_rd]);
      check_eq("write_enable", write_enable, m_we);
      if (m_we) begin
         check_eq("rd", rd, m_rd);
         check_eq("rd_data", rd_data, m_data);
      end
      model_advance();
      @(posedge clk);
      #1;
   endtask

   initial begin
      idle_inputs();
      model_reset();
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      check_eq("rst_we", write_enable, 0);
      check_eq("rst_rd", rd, 0);
      check_eq("rst_rd_data", rd_data, 0);
      check_eq("rst_md_ready", md_ready, 1);
      check_eq("rst_alu_ready", alu_ready, 1);
      check_eq("rst_hazard", hazard, 0);
      rst = 1'b0;

      // single MD result, no bypass, written two edges after the push
      md_valid = 1'b1; md_rd = 5'd5; md_data = 64'hAB;
      step();
      idle_inputs();
      check_eq("nobypass_we", write_enable, 0);
      step();
      check_eq("md_first_we", write_enable, 1);
      check_eq("md_first_rd", rd, 5);
      check_eq("md_first_data", rd_data, 64'hAB);

      // starvation limit forces a one-cycle drain
      md_valid = 1'b1; md_rd = 5'd10; md_data = 64'h55;
      step();
      md_valid = 1'b0;
      alu_valid = 1'b1; alu_rd = 5'd3;
      for (int i = 0; i < LIMIT; i++) begin
         alu_data = 64'h100 + 64'(i);
         step();
         check_eq("starve_alu_we", write_enable, 1);
         check_eq("starve_alu_rd", rd, 3);
         check_eq("starve_alu_data", rd_data, 64'h100 + 64'(i));
      end
      alu_data = 64'h104;
      #1 check_eq("drain_alu_ready", alu_ready, 0);
      step();
      check_eq("drain_rd", rd, 10);
      check_eq("drain_data", rd_data, 64'h55);
      #1 check_eq("post_drain_alu_ready", alu_ready, 1);
      step();
      check_eq("held_alu_rd", rd, 3);
      check_eq("held_alu_data", rd_data, 64'h104);
      idle_inputs();

      // three MD results against a busy ALU with a two-entry FIFO
      order.delete();
      alu_valid = 1'b1; alu_rd = 5'd4; alu_data = 64'h44;
      begin
         int idx;
         idx = 0;
         for (int c = 0; c < 16; c++) begin
            if (c == 9) alu_valid = 1'b0;
            md_valid = (idx < 3);
            md_rd    = 5'(11 + idx);
            md_data  = 64'h200 + 64'(idx);
            if (c == 2) #1 check_eq("third_held_md_ready", md_ready, 0);
            step();
            if (m_md_acc) idx++;
            if (write_enable && rd >= 11 && rd <= 13) order.push_back(int'(rd));
         end
         check_eq("md_accepted_all", idx, 3);
      end
      check_eq("order_count", order.size(), 3);
      if (order.size() == 3) begin
         check_eq("order_0", order[0], 11);
         check_eq("order_1", order[1], 12);
         check_eq("order_2", order[2], 13);
      end
      idle_inputs();

      // hazard on x7 until the cycle after its MD grant
      issue_valid = 1'b1; issue_rd = 5'd7;
      step();
      idle_inputs();
      chk_r2 = 5'd7;
      #1 check_eq("haz7_set", hazard, 1);
      md_valid = 1'b1; md_rd = 5'd7; md_data = 64'h77;
      step();
      md_valid = 1'b0;
      #1 check_eq("haz7_grant_cycle", hazard, 1);
      step();
      check_eq("haz7_clear", hazard, 0);
      idle_inputs();

      // same-cycle clear and set of x9: set wins
      issue_valid = 1'b1; issue_rd = 5'd9;
      step();
      issue_valid = 1'b0;
      md_valid = 1'b1; md_rd = 5'd9; md_data = 64'h99;
      step();
      md_valid = 1'b0;
      issue_valid = 1'b1; issue_rd = 5'd9;
      step();
      idle_inputs();
      chk_r1 = 5'd9;
      #1 check_eq("busy9_set_wins", hazard, 1);
      md_valid = 1'b1; md_rd = 5'd9; md_data = 64'h9A;
      step();
      md_valid = 1'b0;
      step();
      step();
      check_eq("busy9_cleared", hazard, 0);
      idle_inputs();

      // ALU write to x0 is granted but never enabled
      alu_valid = 1'b1; alu_rd = 5'd0; alu_data = 64'hFF;
      #1 check_eq("x0_alu_ready", alu_ready, 1);
      step();
      idle_inputs();
      check_eq("x0_we", write_enable, 0);

      // asynchronous reset with a full FIFO and busy registers
      issue_valid = 1'b1; issue_rd = 5'd15;
      step();
      issue_rd = 5'd16;
      step();
      issue_valid = 1'b0;
      alu_valid = 1'b1; alu_rd = 5'd2; alu_data = 64'h22;
      md_valid = 1'b1; md_rd = 5'd20; md_data = 64'h2020;
      step();
      md_rd = 5'd21; md_data = 64'h2121;
      step();
      idle_inputs();
      chk_r1 = 5'd15; chk_r2 = 5'd16; chk_rd = 5'd20;
      #1;
      check_eq("pre_rst_hazard", hazard, 1);
      check_eq("pre_rst_md_ready", md_ready, 0);
      #1 rst = 1'b1;
      #1;
      check_eq("arst_md_ready", md_ready, 1);
      check_eq("arst_hazard", hazard, 0);
      check_eq("arst_we", write_enable, 0);
      check_eq("arst_alu_ready", alu_ready, 1);
      model_reset();
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;
      for (int c = 0; c < 4; c++) step();
      check_eq("arst_fifo_empty_we", write_enable, 0);

      // randomized traffic with upstream hold-while-not-ready
      for (int c = 0; c < 3000; c++) begin
         if (!(alu_valid && !m_alu_acc)) begin
            alu_valid = ($urandom_range(0, 9) < 6);
            alu_rd    = 5'($urandom_range(0, 31));
            alu_data  = {$urandom, $urandom};
         end
         if (!(md_valid && !m_md_acc)) begin
            md_valid = ($urandom_range(0, 9) < 4);
            md_rd    = 5'($urandom_range(0, 7));
            md_data  = {$urandom, $urandom};
         end
         issue_valid = ($urandom_range(0, 9) < 2);
         issue_rd    = 5'($urandom_range(0, 7));
         chk_r1      = 5'($urandom_range(0, 7));
         chk_r2      = 5'($urandom_range(0, 7));
         chk_rd      = 5'($urandom_range(0, 31));
         step();
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
